// File: rtl/mig_rd_checker.sv
// Read-return checker for the MIG UI: verifies each read beat against the traffic generator's
// running incrementing pattern, counts failures, latches the first one and reports per pass.
module mig_rd_checker #(
    parameter int unsigned APP_DATA_WIDTH = 256,
    parameter int unsigned CHECK_WIDTH    = 32,
    parameter int unsigned BEATS_PER_PASS = 64,
    parameter int unsigned SEED           = 1,
    parameter int unsigned ERR_CNT_WIDTH  = 16,
    localparam int unsigned IDX_WIDTH     = (BEATS_PER_PASS > 1) ? $clog2(BEATS_PER_PASS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      app_rd_data_valid,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
    output logic                      busy,
    output logic                      pass_done,
    output logic                      pass_ok,
    output logic                      error,
    output logic [ERR_CNT_WIDTH-1:0]  err_count,
    output logic [IDX_WIDTH-1:0]      first_err_index,
    output logic [CHECK_WIDTH-1:0]    first_err_data,
    output logic [CHECK_WIDTH-1:0]    first_err_expect,
    output logic [15:0]               pass_count,
    output logic                      heartbeat
);

    localparam logic [IDX_WIDTH-1:0]   LastIdx   = IDX_WIDTH'(BEATS_PER_PASS - 1);
    localparam logic [CHECK_WIDTH-1:0] SeedValue = CHECK_WIDTH'(SEED);

    typedef enum logic [1:0] {StIdle, StCheck, StReport} state_e;

    state_e                 state_q;
    logic [CHECK_WIDTH-1:0] expected_q;
    logic [IDX_WIDTH-1:0]   beat_idx_q;
    logic                   pass_fail_q;

    logic                   in_check;
    logic                   upper_set;
    logic                   beat_bad;
    logic                   beat_fail;
    logic                   last_beat;

    always_comb begin
        in_check  = (state_q == StCheck);
        upper_set = |(app_rd_data >> CHECK_WIDTH);
        beat_bad  = (app_rd_data[CHECK_WIDTH-1:0] != expected_q) || upper_set;
        // Beats outside CHECK are strays and always count as failures.
        beat_fail = app_rd_data_valid && (!in_check || beat_bad);
        last_beat = in_check && app_rd_data_valid && (beat_idx_q == LastIdx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            expected_q       <= SeedValue;
            beat_idx_q       <= '0;
            pass_fail_q      <= 1'b0;
            busy             <= 1'b0;
            pass_done        <= 1'b0;
            pass_ok          <= 1'b0;
            error            <= 1'b0;
            err_count        <= '0;
            first_err_index  <= '0;
            first_err_data   <= '0;
            first_err_expect <= '0;
            pass_count       <= '0;
            heartbeat        <= 1'b0;
        end else begin
            pass_done <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StCheck;
                        busy        <= 1'b1;
                        beat_idx_q  <= '0;
                        pass_fail_q <= 1'b0;
                    end
                end
                StCheck: begin
                    if (app_rd_data_valid) begin
                        // The pattern advances on every accepted beat to stay in step with the
                        // generator, whether or not the beat matched.
                        expected_q <= expected_q + 1'b1;
                        beat_idx_q <= beat_idx_q + 1'b1;
                        if (beat_bad) begin
                            pass_fail_q <= 1'b1;
                        end
                        if (last_beat) begin
                            state_q <= StReport;
                        end
                    end
                end
                StReport: begin
                    state_q    <= StIdle;
                    busy       <= 1'b0;
                    pass_done  <= 1'b1;
                    pass_ok    <= !pass_fail_q;
                    pass_count <= pass_count + 16'd1;
                    if (!pass_fail_q) begin
                        heartbeat <= !heartbeat;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase

            if (beat_fail) begin
                error <= 1'b1;
                if (!(&err_count)) begin
                    err_count <= err_count + 1'b1;
                end
                if (!error) begin
                    first_err_index  <= in_check ? beat_idx_q : '0;
                    first_err_data   <= app_rd_data[CHECK_WIDTH-1:0];
                    first_err_expect <= expected_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mig_rd_checker.sv
// Directed bench for mig_rd_checker: clean passes, corrupted beats, stray beats, mid-pass reset
// and error-counter saturation, all against hand-computed expectations.
module tb_mig_rd_checker;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         app_rd_data_valid;
    logic [255:0] app_rd_data;
    logic         busy;
    logic         pass_done;
    logic         pass_ok;
    logic         error;
    logic [15:0]  err_count;
    logic [5:0]   first_err_index;
    logic [31:0]  first_err_data;
    logic [31:0]  first_err_expect;
    logic [15:0]  pass_count;
    logic         heartbeat;

    int n_vec = 0;
    int n_err = 0;

    mig_rd_checker dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data      (app_rd_data),
        .busy             (busy),
        .pass_done        (pass_done),
        .pass_ok          (pass_ok),
        .error            (error),
        .err_count        (err_count),
        .first_err_index  (first_err_index),
        .first_err_data   (first_err_data),
        .first_err_expect (first_err_expect),
        .pass_count       (pass_count),
        .heartbeat        (heartbeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_pass_done"}, 64'(pass_done), 64'd0);
        check_eq({tag, "_pass_ok"}, 64'(pass_ok), 64'd0);
        check_eq({tag, "_error"}, 64'(error), 64'd0);
        check_eq({tag, "_err_count"}, 64'(err_count), 64'd0);
        check_eq({tag, "_fei"}, 64'(first_err_index), 64'd0);
        check_eq({tag, "_fed"}, 64'(first_err_data), 64'd0);
        check_eq({tag, "_fee"}, 64'(first_err_expect), 64'd0);
        check_eq({tag, "_pass_count"}, 64'(pass_count), 64'd0);
        check_eq({tag, "_heartbeat"}, 64'(heartbeat), 64'd0);
    endtask

    // One pass of 64 beats with low bits base..base+63. Beat bad_idx (if >= 0) is replaced by
    // bad_data. gaps inserts i%4 idle cycles before beat i. start_mid/start_last pulse start
    // while busy, which must be ignored.
    task automatic run_pass(input string tag, input int base, input bit gaps, input int bad_idx,
                            input logic [255:0] bad_data, input bit start_mid,
                            input bit start_last);
        logic [255:0] beat;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq({tag, "_busy_run"}, 64'(busy), 64'd1);
        for (int i = 0; i < 64; i++) begin
            if (gaps && i > 0) repeat (i % 4) step();
            beat = 256'(base + i);
            if (i == bad_idx) beat = bad_data;
            if (start_mid && i == 20) start = 1'b1;
            if (start_last && i == 63) start = 1'b1;
            app_rd_data_valid = 1'b1;
            app_rd_data       = beat;
            step();
            app_rd_data_valid = 1'b0;
            app_rd_data       = '0;
            start             = 1'b0;
        end
        check_eq({tag, "_pd_early"}, 64'(pass_done), 64'd0);
        step();
        check_eq({tag, "_pass_done"}, 64'(pass_done), 64'd1);
        step();
        check_eq({tag, "_pd_pulse"}, 64'(pass_done), 64'd0);
        check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [255:0] bad;
        reset_n           = 1'b0;
        start             = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rd_data       = '0;
        #1;
        check_all_zero("rst");
        do_reset();

        // 1: clean pass, back-to-back, with an ignored start mid-pass
        run_pass("t1", 1, 1'b0, -1, '0, 1'b1, 1'b0);
        check_eq("t1_pass_ok", 64'(pass_ok), 64'd1);
        check_eq("t1_error", 64'(error), 64'd0);
        check_eq("t1_heartbeat", 64'(heartbeat), 64'd1);
        check_eq("t1_pass_count", 64'(pass_count), 64'd1);
        check_eq("t1_err_count", 64'(err_count), 64'd0);

        // 2: pattern continues across passes; gapped valid; start on the last beat ignored
        run_pass("t2", 65, 1'b1, -1, '0, 1'b0, 1'b1);
        check_eq("t2_pass_ok", 64'(pass_ok), 64'd1);
        check_eq("t2_heartbeat", 64'(heartbeat), 64'd0);
        check_eq("t2_pass_count", 64'(pass_count), 64'd2);
        check_eq("t2_error", 64'(error), 64'd0);

        // 3: beat 10 corrupted, then a later mismatch must not move first_err_*
        do_reset();
        run_pass("t3", 1, 1'b0, 10, 256'h0000_DEAD, 1'b0, 1'b0);
        check_eq("t3_error", 64'(error), 64'd1);
        check_eq("t3_err_count", 64'(err_count), 64'd1);
        check_eq("t3_fei", 64'(first_err_index), 64'd10);
        check_eq("t3_fed", 64'(first_err_data), 64'hDEAD);
        check_eq("t3_fee", 64'(first_err_expect), 64'd11);
        check_eq("t3_pass_ok", 64'(pass_ok), 64'd0);
        check_eq("t3_heartbeat", 64'(heartbeat), 64'd0);
        run_pass("t3b", 65, 1'b0, 3, '0, 1'b0, 1'b0);
        check_eq("t3b_err_count", 64'(err_count), 64'd2);
        check_eq("t3b_fei", 64'(first_err_index), 64'd10);
        check_eq("t3b_fed", 64'(first_err_data), 64'hDEAD);
        check_eq("t3b_fee", 64'(first_err_expect), 64'd11);
        check_eq("t3b_pass_ok", 64'(pass_ok), 64'd0);
        check_eq("t3b_pass_count", 64'(pass_count), 64'd2);

        // 4: upper bit set on a beat whose low bits are correct
        do_reset();
        bad = 256'd6;
        bad[200] = 1'b1;
        run_pass("t4", 1, 1'b0, 5, bad, 1'b0, 1'b0);
        check_eq("t4_err_count", 64'(err_count), 64'd1);
        check_eq("t4_fei", 64'(first_err_index), 64'd5);
        check_eq("t4_fed", 64'(first_err_data), 64'd6);
        check_eq("t4_fee", 64'(first_err_expect), 64'd6);
        check_eq("t4_pass_ok", 64'(pass_ok), 64'd0);

        // 5: stray beat in IDLE, expected must not advance
        do_reset();
        app_rd_data_valid = 1'b1;
        app_rd_data       = 256'h55;
        step();
        app_rd_data_valid = 1'b0;
        app_rd_data       = '0;
        check_eq("t5_error", 64'(error), 64'd1);
        check_eq("t5_err_count", 64'(err_count), 64'd1);
        check_eq("t5_fei", 64'(first_err_index), 64'd0);
        check_eq("t5_fed", 64'(first_err_data), 64'h55);
        check_eq("t5_fee", 64'(first_err_expect), 64'd1);
        check_eq("t5_busy", 64'(busy), 64'd0);
        run_pass("t5b", 1, 1'b0, -1, '0, 1'b0, 1'b0);
        check_eq("t5b_pass_ok", 64'(pass_ok), 64'd1);
        check_eq("t5b_err_count", 64'(err_count), 64'd1);
        check_eq("t5b_heartbeat", 64'(heartbeat), 64'd1);

        // 6: reset during beat 30 clears everything at once and yields no pass_done
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = 256'(65 + i);
            step();
        end
        app_rd_data = 256'd95;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        app_rd_data_valid = 1'b0;
        app_rd_data       = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t6_no_pass_done", 64'(pass_done), 64'd0);
        end
        reset_n = 1'b1;
        step();
        run_pass("t6b", 1, 1'b0, -1, '0, 1'b0, 1'b0);
        check_eq("t6b_pass_ok", 64'(pass_ok), 64'd1);
        check_eq("t6b_pass_count", 64'(pass_count), 64'd1);
        check_eq("t6b_error", 64'(error), 64'd0);

        // Saturation: 2^16+5 stray beats
        app_rd_data_valid = 1'b1;
        app_rd_data       = '0;
        repeat (65536 + 5) step();
        app_rd_data_valid = 1'b0;
        step();
        check_eq("sat_err_count", 64'(err_count), 64'hFFFF);
        check_eq("sat_error", 64'(error), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
